pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
Parametrised successor of the fixed 4-phase pipeline state controller. It sequences a single in-flight instruction through NUM_STAGES phases (decode, setup, execute, ..., writeback) and presents both a binary index and a one-hot stage vector to the datapath. It adds stall, flush, graceful halt and retire counting. It sits between the top-level core control (start/halt) and all per-stage datapath enables.

Parameters:
NUM_STAGES, 4, number of pipeline phases; must be >= 2.
STAGE_W, $clog2(NUM_STAGES), width of the stage index.
CNT_W, 32, width of the retire counter (and of the stall counter when enabled).

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
start  input  1  level; begins sequencing when IDLE.
stall  input  1  holds the current stage for this cycle.
flush  input  1  aborts the current instruction and restarts at stage 0.
halt_req  input  1  pulse; stop after the current instruction retires.
active  output  1  high in RUN or DRAIN.
stage_idx  output  STAGE_W  current stage number.
stage_onehot  output  NUM_STAGES  one-hot of stage_idx; bit k is high when stage_idx==k, whether active or not.
stage_adv  output  1  stage advances at the end of this cycle.
retire  output  1  one-cycle pulse; the last stage completes this cycle.
retire_count  output  CNT_W  count of retired instructions.
stall_count  output  CNT_W  count of stall cycles (optional feature only).

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE, stage_idx=0, stage_onehot=1.
  - active=0, stage_adv=0, retire=0.
  - retire_count=0, stall_count=0, halt_pending=0.
- stage_onehot is decoded combinationally from registered stage_idx. Zero lag, unlike the previous generation.
- States and transitions:
  - IDLE: stage_idx held at 0. If start=1, move to RUN next cycle; stage 0 becomes active in that cycle.
  - RUN: stage_adv = ~stall & ~flush. On stage_adv, stage_idx increments. At NUM_STAGES-1 it wraps to 0, and retire=1 in that same cycle.
  - DRAIN: entered from RUN when halt_req=1. Advances like RUN. On retire, moves to IDLE; stage_idx ends at 0.
- Halt while already in IDLE has no effect.
- Halt arriving in the same cycle as retire: the current instruction is the last one, and the next state is IDLE.
- Control priority each cycle: reset > flush > stall > advance.
- flush in RUN/DRAIN:
  - stage_idx <= 0, with no retire and no count increment.
  - State is unchanged: RUN continues, DRAIN stays in DRAIN.
- flush in IDLE is ignored.
- stall:
  - stage_idx holds and stage_adv=0.
  - retire is suppressed even at the last stage.
  - stall in IDLE is ignored.
- Counters:
  - retire_count increments by 1 on each retire.
  - It wraps modulo 2^CNT_W with no saturation.
- start held high in RUN has no effect. After return to IDLE, start high restarts RUN on the following cycle.
- Latency: start accepted -> stage 0 active next cycle. Each instruction takes NUM_STAGES unstalled cycles.

Optional Feature:
PIPE_SEQ_STALL_CNT_EN
- Defined: stall_count increments every cycle that active=1 & stall=1 & ~flush. It wraps modulo 2^CNT_W and is cleared by reset.
- Undefined: stall_count is tied to 0 and no counter flops are generated. The port is always present.

Decomposition:
- Package pipe_seq_pkg holds:
  - state enum {IDLE, RUN, DRAIN} on 2 bits;
  - default NUM_STAGES and CNT_W constants;
  - canonical stage-name localparams STG_DECODE=0, STG_SETUP=1, STG_EXECUTE=2, STG_WRITEBACK=3.
- Sub-module stage_onehot_dec (parameter N): combinational binary-to-one-hot, reused by the datapath.

Test Plan:
1. Reset, then start=1 for 1 cycle with NUM_STAGES=4 -> stage_idx 0,1,2,3,0,...; retire pulses every 4th cycle; retire_count=3 after 12 cycles.
2. stall=1 for 3 cycles at stage 2 -> stage_idx holds at 2 for 3 extra cycles; no retire during the stall; with the macro defined, stall_count=3.
3. flush at stage 3 -> next stage_idx=0, retire=0, retire_count unchanged, active stays 1.
4. halt_req at stage 1 -> stages 2,3 complete, retire pulses once, then active=0, stage_idx=0, stage_onehot=4'b0001.
5. Mid-RUN reset at stage 2 -> next cycle all outputs at their reset values and retire_count=0.
6. NUM_STAGES=5, CNT_W=3, run 9 instructions -> wrap at stage 4 confirmed; retire_count=1 (9 mod 8).

Source files
------------

// File: rtl/pipe_seq_pkg.sv
// -----------------------------------------------------------------------------
// pipe_seq_pkg
// Shared definitions for the pipeline sequencer and the datapath that
// consumes its stage vector: FSM state encoding, default sizing and the
// canonical names of the first four pipeline phases.
// -----------------------------------------------------------------------------
package pipe_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Default sizing
    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_CNT_W      = 32;

    // Canonical stage numbers for the classic 4-phase datapath
    localparam int STG_DECODE    = 0;
    localparam int STG_SETUP     = 1;
    localparam int STG_EXECUTE   = 2;
    localparam int STG_WRITEBACK = 3;

endpackage

// File: rtl/stage_onehot_dec.sv
// -----------------------------------------------------------------------------
// stage_onehot_dec
// Combinational binary-to-one-hot decoder. Bit k of o_onehot is high when
// i_idx == k. Indices >= N decode to all zeros.
// Ports:
//   i_idx     W-bit binary stage index
//   o_onehot  N-bit one-hot vector
// -----------------------------------------------------------------------------
module stage_onehot_dec #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] i_idx,
    output logic [N-1:0] o_onehot
);

    // Decode the binary index into a one-hot vector
    always_comb begin
        o_onehot = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (i_idx == W'(k)) begin
                o_onehot[k] = 1'b1;
            end else begin
                o_onehot[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
// Steps a single in-flight instruction through NUM_STAGES phases and presents
// the current phase both as a binary index and a one-hot vector. Supports
// stall (hold), flush (restart at stage 0), graceful halt (finish the current
// instruction, then go idle) and retire counting.
//
// Optional build macro: PIPE_SEQ_STALL_CNT_EN
//   defined   -> stall_count counts active, stalled, non-flushed cycles
//   undefined -> stall_count is tied to zero, no counter flops
//
// Ports:
//   clk           clock
//   reset         synchronous active-high reset
//   start         level; begins sequencing from IDLE
//   stall         hold the current stage this cycle
//   flush         abort current instruction, restart at stage 0
//   halt_req      pulse; stop once the current instruction retires
//   active        high in RUN or DRAIN
//   stage_idx     current stage number
//   stage_onehot  one-hot of stage_idx (valid even when idle)
//   stage_adv     stage advances at the end of this cycle
//   retire        last stage completes this cycle
//   retire_count  retired instruction count (wraps)
//   stall_count   stall cycle count (optional feature, else 0)
// -----------------------------------------------------------------------------
module pipeline_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int STAGE_W    = $clog2(NUM_STAGES),
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  halt_req,
    output logic                  active,
    output logic [STAGE_W-1:0]    stage_idx,
    output logic [NUM_STAGES-1:0] stage_onehot,
    output logic                  stage_adv,
    output logic                  retire,
    output logic [CNT_W-1:0]      retire_count,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    state_t               r_state;
    logic [STAGE_W-1:0]   r_stage_idx;
    logic [CNT_W-1:0]     r_retire_count;

    logic                 w_busy;
    logic                 w_stage_adv;
    logic                 w_retire;
    logic [STAGE_W-1:0]   w_stage_nxt;

    // RUN and DRAIN advance identically; only the exit condition differs.
    // Reset is folded in so the strobes read zero while reset is asserted.
    assign w_busy      = (r_state != IDLE);
    assign w_stage_adv = ~reset & w_busy & ~stall & ~flush;
    assign w_retire    = w_stage_adv & (r_stage_idx == LAST_STAGE);

    // Next stage index: flush wins over stall, stall wins over advance
    always_comb begin
        w_stage_nxt = r_stage_idx;
        if (!w_busy) begin
            w_stage_nxt = {STAGE_W{1'b0}};
        end else if (flush) begin
            w_stage_nxt = {STAGE_W{1'b0}};
        end else if (stall) begin
            w_stage_nxt = r_stage_idx;
        end else if (r_stage_idx == LAST_STAGE) begin
            w_stage_nxt = {STAGE_W{1'b0}};
        end else begin
            w_stage_nxt = r_stage_idx + STAGE_W'(1);
        end
    end

    // Sequencer FSM, stage register and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_stage_idx    <= {STAGE_W{1'b0}};
            r_retire_count <= {CNT_W{1'b0}};
        end else begin
            r_stage_idx <= w_stage_nxt;
            if (w_retire) begin
                r_retire_count <= r_retire_count + CNT_W'(1);
            end else begin
                r_retire_count <= r_retire_count;
            end
            case (r_state)
                IDLE: begin
                    // halt, stall and flush have no meaning while idle
                    if (start) begin
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // A halt coinciding with retire makes this the last one
                    if (halt_req && w_retire) begin
                        r_state <= IDLE;
                    end else if (halt_req) begin
                        r_state <= DRAIN;
                    end else begin
                        r_state <= RUN;
                    end
                end
                DRAIN: begin
                    if (w_retire) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef PIPE_SEQ_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_count;

    // Count cycles the pipe is held by stall (flush takes precedence)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= {CNT_W{1'b0}};
        end else if (w_busy && stall && !flush) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = {CNT_W{1'b0}};
`endif

    stage_onehot_dec #(
        .N (NUM_STAGES),
        .W (STAGE_W)
    ) u_onehot_dec (
        .i_idx    (r_stage_idx),
        .o_onehot (stage_onehot)
    );

    assign active       = w_busy;
    assign stage_idx    = r_stage_idx;
    assign stage_adv    = w_stage_adv;
    assign retire       = w_retire;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus a
// randomized run against a behavioural model, and a second instance with
// 5 stages and a 3-bit retire counter for wrap behaviour.
module tb_pipeline_sequencer;

    localparam int NS_A = 4;
    localparam int NS_B = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default 4 stages, 32-bit counters
    logic        reset = 1'b1, start = 1'b0, stall = 1'b0, flush = 1'b0, halt_req = 1'b0;
    logic        active, stage_adv, retire;
    logic [1:0]  stage_idx;
    logic [3:0]  stage_onehot;
    logic [31:0] retire_count, stall_count;

    // Instance B: 5 stages, 3-bit counters
    logic        b_reset = 1'b1, b_start = 1'b0;
    logic        b_active, b_stage_adv, b_retire;
    logic [2:0]  b_stage_idx;
    logic [4:0]  b_stage_onehot;
    logic [2:0]  b_retire_count, b_stall_count;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of instance A
    bit          m_busy  = 1'b0;
    bit          m_drain = 1'b0;
    int          m_stage = 0;
    logic [31:0] m_rcnt  = 32'd0;
    logic [31:0] m_scnt  = 32'd0;

    pipeline_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .flush(flush),
        .halt_req(halt_req), .active(active), .stage_idx(stage_idx),
        .stage_onehot(stage_onehot), .stage_adv(stage_adv), .retire(retire),
        .retire_count(retire_count), .stall_count(stall_count)
    );

    pipeline_sequencer #(.NUM_STAGES(NS_B), .CNT_W(3)) dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .stall(1'b0), .flush(1'b0),
        .halt_req(1'b0), .active(b_active), .stage_idx(b_stage_idx),
        .stage_onehot(b_stage_onehot), .stage_adv(b_stage_adv), .retire(b_retire),
        .retire_count(b_retire_count), .stall_count(b_stall_count)
    );

    function automatic bit exp_adv();
        return !reset && m_busy && !stall && !flush;
    endfunction

    function automatic bit exp_retire();
        return exp_adv() && (m_stage == NS_A - 1);
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        bit ret;
        @(posedge clk);
        ret = exp_retire();
        if (reset) begin
            m_busy = 1'b0; m_drain = 1'b0; m_stage = 0; m_rcnt = 32'd0; m_scnt = 32'd0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1; m_drain = 1'b0; m_stage = 0;
            end
        end else begin
            if (stall && !flush) m_scnt = m_scnt + 32'd1;
            if (flush) m_stage = 0;
            else if (!stall) m_stage = (m_stage + 1) % NS_A;
            if (ret) m_rcnt = m_rcnt + 32'd1;
            if (ret && (m_drain || halt_req)) begin
                m_busy = 1'b0; m_drain = 1'b0;
            end else if (halt_req) begin
                m_drain = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        tick(); tick();
        #1;
        n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
        n_cmp++; if (stage_idx !== 2'd0) begin n_err++; $display("FAIL reset_stage_idx: got %0d want 0", stage_idx); end
        n_cmp++; if (stage_onehot !== 4'b0001) begin n_err++; $display("FAIL reset_onehot: got %b want 0001", stage_onehot); end
        n_cmp++; if (stage_adv !== 1'b0 || retire !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got adv=%b ret=%b want 0 0", stage_adv, retire); end
        n_cmp++; if (retire_count !== 32'd0 || stall_count !== 32'd0) begin n_err++; $display("FAIL reset_counts: got r=%0d s=%0d want 0 0", retire_count, stall_count); end
        reset = 1'b0; start = 1'b0;
    endtask

    task automatic test_run();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            n_cmp++;
            if (stage_idx !== 2'(i % 4) || stage_onehot !== 4'(1 << (i % 4)) ||
                retire !== (i % 4 == 3) || active !== 1'b1) begin
                n_err++;
                $display("FAIL run_seq cyc %0d: got idx=%0d oh=%b ret=%b act=%b want idx=%0d ret=%0d act=1",
                         i, stage_idx, stage_onehot, retire, active, i % 4, (i % 4 == 3));
            end
            tick();
        end
        n_cmp++; if (retire_count !== 32'd3) begin n_err++; $display("FAIL run_count: got %0d want 3", retire_count); end
    endtask

    task automatic test_stall();
        logic [31:0] sc0;
        sc0 = stall_count;
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (stage_idx !== 2'd2 || stage_adv !== 1'b0 || retire !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold cyc %0d: got idx=%0d adv=%b ret=%b want 2 0 0", i, stage_idx, stage_adv, retire);
            end
            tick();
        end
        stall = 1'b0; #1;
        n_cmp++; if (stage_idx !== 2'd2 || stage_adv !== 1'b1) begin n_err++; $display("FAIL stall_release: got idx=%0d adv=%b want 2 1", stage_idx, stage_adv); end
`ifdef PIPE_SEQ_STALL_CNT_EN
        n_cmp++; if (stall_count - sc0 !== 32'd3) begin n_err++; $display("FAIL stall_count: got %0d want 3", stall_count - sc0); end
`else
        n_cmp++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL stall_count_off: got %0d want 0", stall_count); end
`endif
        tick();
        stall = 1'b1; #1;
        n_cmp++; if (stage_idx !== 2'd3 || retire !== 1'b0) begin n_err++; $display("FAIL stall_last: got idx=%0d ret=%b want 3 0", stage_idx, retire); end
        tick(); stall = 1'b0; #1;
        n_cmp++; if (retire !== 1'b1) begin n_err++; $display("FAIL stall_last_release: got ret=%b want 1", retire); end
        tick();
    endtask

    task automatic test_flush();
        tick(); tick(); tick();
        flush = 1'b1; #1;
        n_cmp++; if (stage_idx !== 2'd3 || retire !== 1'b0 || stage_adv !== 1'b0) begin n_err++; $display("FAIL flush_strobes: got idx=%0d ret=%b adv=%b want 3 0 0", stage_idx, retire, stage_adv); end
        tick(); flush = 1'b0; #1;
        n_cmp++; if (stage_idx !== 2'd0 || active !== 1'b1 || retire_count !== 32'd4) begin n_err++; $display("FAIL flush_after: got idx=%0d act=%b cnt=%0d want 0 1 4", stage_idx, active, retire_count); end
        tick(); tick();
        flush = 1'b1; stall = 1'b1;
        tick(); flush = 1'b0; stall = 1'b0; #1;
        n_cmp++; if (stage_idx !== 2'd0) begin n_err++; $display("FAIL flush_over_stall: got idx=%0d want 0", stage_idx); end
    endtask

    task automatic test_halt();
        tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0; #1;
        n_cmp++; if (active !== 1'b1 || stage_idx !== 2'd2) begin n_err++; $display("FAIL halt_drain: got act=%b idx=%0d want 1 2", active, stage_idx); end
        tick(); #1;
        n_cmp++; if (stage_idx !== 2'd3 || retire !== 1'b1) begin n_err++; $display("FAIL halt_retire: got idx=%0d ret=%b want 3 1", stage_idx, retire); end
        tick(); #1;
        n_cmp++; if (active !== 1'b0 || stage_idx !== 2'd0 || stage_onehot !== 4'b0001 || retire_count !== 32'd5) begin
            n_err++; $display("FAIL halt_idle: got act=%b idx=%0d oh=%b cnt=%0d want 0 0 0001 5", active, stage_idx, stage_onehot, retire_count); end
        halt_req = 1'b1; flush = 1'b1; stall = 1'b1;
        tick(); halt_req = 1'b0; flush = 1'b0; stall = 1'b0; #1;
        n_cmp++; if (active !== 1'b0 || stage_idx !== 2'd0 || stage_adv !== 1'b0) begin n_err++; $display("FAIL idle_ignore: got act=%b idx=%0d adv=%b want 0 0 0", active, stage_idx, stage_adv); end
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        halt_req = 1'b1; #1;
        n_cmp++; if (retire !== 1'b1) begin n_err++; $display("FAIL halt_at_retire_pulse: got %b want 1", retire); end
        tick(); halt_req = 1'b0; #1;
        n_cmp++; if (active !== 1'b0 || retire_count !== 32'd6) begin n_err++; $display("FAIL halt_at_retire: got act=%b cnt=%0d want 0 6", active, retire_count); end
        start = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (stage_idx !== 2'(i) || active !== 1'b1) begin n_err++; $display("FAIL start_held cyc %0d: got idx=%0d act=%b want %0d 1", i, stage_idx, active, i); end
            tick();
        end
        start = 1'b0;
        tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0; #1;
        n_cmp++; if (stage_idx !== 2'd0 || active !== 1'b1) begin n_err++; $display("FAIL drain_flush: got idx=%0d act=%b want 0 1", stage_idx, active); end
        tick(); tick(); tick(); #1;
        n_cmp++; if (retire !== 1'b1) begin n_err++; $display("FAIL drain_flush_retire: got %b want 1", retire); end
        tick(); #1;
        n_cmp++; if (active !== 1'b0 || retire_count !== 32'd8) begin n_err++; $display("FAIL drain_flush_idle: got act=%b cnt=%0d want 0 8", active, retire_count); end
    endtask

    task automatic test_mid_reset();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0; #1;
        n_cmp++; if (active !== 1'b0 || stage_idx !== 2'd0 || stage_onehot !== 4'b0001 ||
                     stage_adv !== 1'b0 || retire !== 1'b0 || retire_count !== 32'd0 || stall_count !== 32'd0) begin
            n_err++; $display("FAIL mid_reset: got act=%b idx=%0d oh=%b adv=%b ret=%b rc=%0d sc=%0d want all reset",
                              active, stage_idx, stage_onehot, stage_adv, retire, retire_count, stall_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            reset    = ($urandom_range(0, 149) == 0);
            start    = ($urandom_range(0, 3) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            halt_req = ($urandom_range(0, 11) == 0);
            #1;
            n_cmp++;
            if (active !== m_busy || stage_idx !== 2'(m_stage) || stage_onehot !== 4'(1 << m_stage) ||
                stage_adv !== exp_adv() || retire !== exp_retire() || retire_count !== m_rcnt) begin
                n_err++;
                $display("FAIL random cyc %0d: got act=%b idx=%0d oh=%b adv=%b ret=%b rc=%0d want act=%b idx=%0d adv=%b ret=%b rc=%0d",
                         i, active, stage_idx, stage_onehot, stage_adv, retire, retire_count,
                         m_busy, m_stage, exp_adv(), exp_retire(), m_rcnt);
            end
`ifdef PIPE_SEQ_STALL_CNT_EN
            n_cmp++; if (stall_count !== m_scnt) begin n_err++; $display("FAIL random_stall_count cyc %0d: got %0d want %0d", i, stall_count, m_scnt); end
`endif
            tick();
        end
        reset = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_wrap();
        b_reset = 1'b1; tick(); b_reset = 1'b0;
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int i = 0; i < 45; i++) begin
            #1;
            n_cmp++;
            if (b_stage_idx !== 3'(i % 5) || b_stage_onehot !== 5'(1 << (i % 5)) ||
                b_retire !== (i % 5 == 4) || b_retire_count !== 3'((i / 5) % 8)) begin
                n_err++;
                $display("FAIL wrap cyc %0d: got idx=%0d oh=%b ret=%b cnt=%0d want idx=%0d ret=%0d cnt=%0d",
                         i, b_stage_idx, b_stage_onehot, b_retire, b_retire_count, i % 5, (i % 5 == 4), (i / 5) % 8);
            end
            tick();
        end
        #1;
        n_cmp++; if (b_retire_count !== 3'd1 || b_stall_count !== 3'd0) begin n_err++; $display("FAIL wrap_count: got rc=%0d sc=%0d want 1 0", b_retire_count, b_stall_count); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_flush();
        test_halt();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
